// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed latency.
// Each request is accepted in IDLE, waits LATENCY cycles in BUSY, performs its
// word access on the final BUSY edge, then holds the response in RESP until
// the initiator takes it. All state, including the array, clears on reset.
// Optional feature macro: DMEM_ALIGN_CHECK_EN rejects misaligned addresses
// with resp_err=1 and no memory access.
module dmem_responder #(
  parameter int MEM_WORDS = 16384,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [MEM_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              access;

  // Higher address bits select nothing: out-of-range addresses wrap.
  assign idx    = addr_q[IDX_W+1:2];
  assign accept = (state == IDLE) && req_valid;
  assign access = (state == BUSY) && (cnt == 4'd0);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  logic err_q;
  logic addr_unused;
  assign misaligned  = (addr_q[1:0] != 2'b00);
  assign resp_err    = err_q;
  assign addr_unused = ^addr_q[31:IDX_W+2];
`else
  logic addr_unused;
  assign resp_err    = 1'b0;
  assign addr_unused = ^{addr_q[31:IDX_W+2], addr_q[1:0]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid)  next_state = BUSY;
      BUSY:    if (cnt == 4'd0) next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY - 1);
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if ((state == BUSY) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Memory array and response registers; the array is touched only on the
  // access edge, so a load after a store to the same word sees the new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is part of the reset domain because a reset must leave
      // every word reading zero; this forces flops rather than a RAM macro.
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
      resp_rdata <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q <= 1'b0;
`endif
    end else if (access) begin
`ifdef DMEM_ALIGN_CHECK_EN
      err_q <= misaligned;
      if (misaligned) begin
        resp_rdata <= 32'd0;
      end else
`endif
      if (write_q) begin
        mem[idx]   <= wdata_q;
        resp_rdata <= 32'd0;
      end else begin
        resp_rdata <= mem[idx];
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter LATENCY, default 4, clock cycles from request accept to response valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port resp_valid  output  1  response presented.
REQ-011 SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-012 SHALL have port resp_rdata  output  32  load data; 0 for stores.
REQ-013 SHALL have port resp_err  output  1  access rejected (see Configuration).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE and resp_valid=1 only in RESP.
REQ-016 In IDLE, on an edge with req_valid=1: SHALL latch req_write, req_addr and req_wdata, load the counter with LATENCY-1, and go to BUSY.
REQ-017 In BUSY, while counter>0: SHALL decrement the counter each edge; req_* inputs are ignored.
REQ-018 In BUSY, on the edge with counter==0: SHALL perform the access and go to RESP, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-019 Access word index SHALL be latched addr[log2(MEM_WORDS)+1:2]; higher address bits are ignored, so out-of-range addresses wrap.
REQ-020 A store SHALL commit the whole word on the access edge and set resp_rdata=0.
REQ-021 A load SHALL register mem[index] into resp_rdata on the access edge.
REQ-022 In RESP: resp_rdata and resp_err SHALL stay stable until an edge with resp_ready=1, which returns the FSM to IDLE.
REQ-023 resp_ready SHALL be ignored outside RESP, and req_valid SHALL be ignored outside IDLE.
REQ-024 Back-to-back transfers SHALL incur at least one IDLE cycle between a response handshake and the next accept.
REQ-025 The array SHALL be read only at the access edge, so a load issued after a store to the same word returns the stored data.

Reset
REQ-026 When reset=1 at an edge: SHALL enter IDLE, clear the counter, clear resp_valid, resp_rdata and resp_err to 0, and zero all memory words.
REQ-027 A reset during BUSY or RESP SHALL abort the transfer; a store not yet at its access edge SHALL NOT commit.
REQ-028 In the first cycle after reset deasserts: req_ready=1 and resp_valid=0.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN, when defined: a latched address with addr[1:0]!=0 SHALL perform no memory read or write and SHALL respond at the normal latency with resp_err=1 and resp_rdata=0.
REQ-030 Without DMEM_ALIGN_CHECK_EN: addr[1:0] SHALL be ignored and resp_err SHALL be constant 0.

Verification
REQ-031 Reset, then load addr 0x40 with LATENCY=4 -> resp_valid rises 4 cycles after the accept; resp_rdata=0x00000000.
REQ-032 Store 0xDEADBEEF to 0x100, then load 0x100 -> store response has rdata 0; load returns 0xDEADBEEF.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP while pulsing req_valid -> resp_valid and resp_rdata stay stable, req_ready=0, and no second request is accepted.
REQ-034 Store 0x12345678 with reset asserted in BUSY before the access edge, then load the same address -> returns 0.
REQ-035 Store to 0x0001_0000 with MEM_WORDS=16384, then load 0x0 -> returns the stored value (wrap).
REQ-036 With DMEM_ALIGN_CHECK_EN defined, store to 0x102, then load 0x100 -> store response has resp_err=1; load returns the prior content with resp_err=0.
